// File: rtl/crc16_frame_checker.sv
// Receive-side CRC-16 (poly 0x8005, init 0, MSB-first) frame checker.
// Strips the two trailing CRC bytes, forwards payload, and reports a per-frame verdict.
module crc16_frame_checker #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             out_valid,
    output logic [7:0]       out_data,
    output logic             out_last,
    output logic             frame_done,
    output logic             crc_ok,
    output logic             crc_err,
    output logic             short_err,
    output logic [LEN_W-1:0] frame_len
);

    // IDLE/ONE/BODY = number of bytes currently held in the delay line (0/1/2)
    typedef enum logic [1:0] {
        S_IDLE,
        S_ONE,
        S_BODY
    } state_t;

    localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t           r_state, w_state_nxt;
    logic [15:0]      r_crc, w_crc_nxt, w_crc_step;
    logic [7:0]       r_dly_new, r_dly_old, w_dly_new_nxt, w_dly_old_nxt;
    logic [LEN_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;

    logic             r_out_valid, w_out_valid_nxt;
    logic [7:0]       r_out_data, w_out_data_nxt;
    logic             r_out_last, w_out_last_nxt;
    logic             r_frame_done, w_frame_done_nxt;
    logic             r_crc_ok, w_crc_ok_nxt;
    logic             r_crc_err, w_crc_err_nxt;
    logic             r_short_err, w_short_err_nxt;
    logic [LEN_W-1:0] r_frame_len, w_frame_len_nxt;

    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] v;
        v = crc;
        for (int i = 7; i >= 0; i--) begin
            if (v[15] ^ data[i]) v = {v[14:0], 1'b0} ^ 16'h8005;
            else                 v = {v[14:0], 1'b0};
        end
        return v;
    endfunction

    assign w_crc_step = crc16_byte(r_crc, in_data);
    assign w_cnt_inc  = (&r_cnt) ? r_cnt : r_cnt + LEN_ONE;

    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned (no latches).
    always_comb begin
        w_state_nxt      = r_state;
        w_crc_nxt        = r_crc;
        w_dly_new_nxt    = r_dly_new;
        w_dly_old_nxt    = r_dly_old;
        w_cnt_nxt        = r_cnt;
        w_out_valid_nxt  = 1'b0;
        w_out_data_nxt   = r_out_data;
        w_out_last_nxt   = 1'b0;
        w_frame_done_nxt = 1'b0;
        w_crc_ok_nxt     = 1'b0;
        w_crc_err_nxt    = 1'b0;
        w_short_err_nxt  = 1'b0;
        w_frame_len_nxt  = r_frame_len;

        if (in_valid) begin
            if (in_last) begin
                w_state_nxt      = S_IDLE;
                w_crc_nxt        = 16'h0000;
                w_dly_new_nxt    = 8'h00;
                w_dly_old_nxt    = 8'h00;
                w_cnt_nxt        = '0;
                w_frame_done_nxt = 1'b1;
                case (r_state)
                    S_ONE: begin
                        w_crc_ok_nxt    = (w_crc_step == 16'h0000);
                        w_crc_err_nxt   = (w_crc_step != 16'h0000);
                        w_frame_len_nxt = '0;
                    end
                    S_BODY: begin
                        w_crc_ok_nxt    = (w_crc_step == 16'h0000);
                        w_crc_err_nxt   = (w_crc_step != 16'h0000);
                        w_out_valid_nxt = 1'b1;
                        w_out_data_nxt  = r_dly_old;
                        w_out_last_nxt  = 1'b1;
                        w_frame_len_nxt = w_cnt_inc;
                    end
                    default: begin
                        w_crc_err_nxt   = 1'b1;
                        w_short_err_nxt = 1'b1;
                        w_frame_len_nxt = '0;
                    end
                endcase
            end else begin
                w_crc_nxt     = w_crc_step;
                w_dly_new_nxt = in_data;
                w_dly_old_nxt = r_dly_new;
                case (r_state)
                    S_IDLE: w_state_nxt = S_ONE;
                    S_ONE:  w_state_nxt = S_BODY;
                    S_BODY: begin
                        // Oldest held byte is payload: the last two held bytes are always the CRC
                        w_out_valid_nxt = 1'b1;
                        w_out_data_nxt  = r_dly_old;
                        w_cnt_nxt       = w_cnt_inc;
                    end
                    default: w_state_nxt = S_IDLE;
                endcase
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_crc        <= 16'h0000;
            r_dly_new    <= 8'h00;
            r_dly_old    <= 8'h00;
            r_cnt        <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= 8'h00;
            r_out_last   <= 1'b0;
            r_frame_done <= 1'b0;
            r_crc_ok     <= 1'b0;
            r_crc_err    <= 1'b0;
            r_short_err  <= 1'b0;
            r_frame_len  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_crc        <= w_crc_nxt;
            r_dly_new    <= w_dly_new_nxt;
            r_dly_old    <= w_dly_old_nxt;
            r_cnt        <= w_cnt_nxt;
            r_out_valid  <= w_out_valid_nxt;
            r_out_data   <= w_out_data_nxt;
            r_out_last   <= w_out_last_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_crc_ok     <= w_crc_ok_nxt;
            r_crc_err    <= w_crc_err_nxt;
            r_short_err  <= w_short_err_nxt;
            r_frame_len  <= w_frame_len_nxt;
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_last   = r_out_last;
    assign frame_done = r_frame_done;
    assign crc_ok     = r_crc_ok;
    assign crc_err    = r_crc_err;
    assign short_err  = r_short_err;
    assign frame_len  = r_frame_len;

endmodule

// File: tb/tb_crc16_frame_checker.sv
// Scoreboard bench for crc16_frame_checker: expected payload bytes and verdicts are queued
// when frames are driven and compared by a monitor when the DUT produces them.
module tb_crc16_frame_checker;

    localparam int LEN_W = 4;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [7:0] d;
        logic       l;
    } pay_t;
    typedef struct {
        logic             ok;
        logic             short_f;
        logic [LEN_W-1:0] len;
    } verd_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic [7:0]       in_data = 8'h00;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic [7:0]       out_data;
    logic             out_last;
    logic             frame_done;
    logic             crc_ok;
    logic             crc_err;
    logic             short_err;
    logic [LEN_W-1:0] frame_len;

    pay_t             pay_q[$];
    verd_t            verd_q[$];
    int               checks = 0;
    int               errors = 0;
    logic [LEN_W-1:0] exp_len = '0;

    crc16_frame_checker #(.LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .frame_done(frame_done),
        .crc_ok    (crc_ok),
        .crc_err   (crc_err),
        .short_err (short_err),
        .frame_len (frame_len)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // Bit-serial reference LFSR (one message bit per shift)
    function automatic logic [15:0] ref_crc(input bq_t msg);
        logic [15:0] c;
        logic        fb;
        c = 16'h0000;
        foreach (msg[i]) begin
            for (int b = 7; b >= 0; b--) begin
                fb = c[15] ^ msg[i][b];
                c  = c << 1;
                if (fb) c = c ^ 16'h8005;
            end
        end
        return c;
    endfunction

    // Monitor: every DUT output event must match the head of its queue
    always @(negedge clk) begin : monitor
        pay_t  p;
        verd_t v;
        if (!rst) begin
            if (out_valid) begin
                checks++;
                if (pay_q.size() == 0) begin
                    errors++;
                    $display("FAIL payload_unexpected: got data=%h last=%b, none expected", out_data, out_last);
                end else begin
                    p = pay_q.pop_front();
                    if ({out_data, out_last} !== {p.d, p.l}) begin
                        errors++;
                        $display("FAIL payload: got data=%h last=%b, expected data=%h last=%b",
                                 out_data, out_last, p.d, p.l);
                    end
                end
            end
            if (frame_done) begin
                checks++;
                if (verd_q.size() == 0) begin
                    errors++;
                    $display("FAIL verdict_unexpected: got ok=%b err=%b short=%b len=%0d, none expected",
                             crc_ok, crc_err, short_err, frame_len);
                end else begin
                    v = verd_q.pop_front();
                    if ({crc_ok, crc_err, short_err, frame_len} !== {v.ok, ~v.ok, v.short_f, v.len}) begin
                        errors++;
                        $display("FAIL verdict: got ok=%b err=%b short=%b len=%0d, expected ok=%b err=%b short=%b len=%0d",
                                 crc_ok, crc_err, short_err, frame_len, v.ok, ~v.ok, v.short_f, v.len);
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Idle cycles with junk on data/last, which must be ignored while in_valid=0
    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            in_data = 8'($urandom);
            in_last = 1'($urandom);
            @(posedge clk);
            #1;
        end
        in_last = 1'b0;
    endtask

    task automatic send_frame(input bq_t f, input int gap_max);
        for (int i = 0; i < f.size(); i++) begin
            send_byte(f[i], i == f.size() - 1);
            if (gap_max > 0 && i < f.size() - 1) gap($urandom_range(0, gap_max));
        end
    endtask

    task automatic expect_frame(input bq_t f, input logic ok);
        verd_t v;
        pay_pushes : for (int i = 0; i + 2 < f.size(); i++)
            pay_q.push_back('{d: f[i], l: (i + 3 == f.size())});
        v.ok      = (f.size() < 2) ? 1'b0 : ok;
        v.short_f = (f.size() < 2);
        v.len     = (f.size() < 2) ? '0 : ((f.size() - 2 > 2**LEN_W - 1) ? '1 : LEN_W'(f.size() - 2));
        exp_len   = v.len;
        verd_q.push_back(v);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((pay_q.size() != 0 || verd_q.size() != 0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checks++;
        if (pay_q.size() != 0 || verd_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d payload / %0d verdicts outstanding, expected 0/0",
                     name, pay_q.size(), verd_q.size());
            pay_q.delete();
            verd_q.delete();
        end
        checks++;
        if (frame_len !== exp_len) begin
            errors++;
            $display("FAIL %s_len_hold: got frame_len=%0d, expected %0d", name, frame_len, exp_len);
        end
    endtask

    function automatic bq_t good_frame();
        bq_t f;
        f = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hFE, 8'hE8};
        return f;
    endfunction

    task automatic check_outputs_zero(input string name);
        checks++;
        if ({out_valid, out_data, out_last, frame_done, crc_ok, crc_err, short_err, frame_len} !== '0) begin
            errors++;
            $display("FAIL %s: got valid=%b data=%h last=%b done=%b ok=%b err=%b short=%b len=%0d, expected all 0",
                     name, out_valid, out_data, out_last, frame_done, crc_ok, crc_err, short_err, frame_len);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        check_outputs_zero("reset_state");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_outputs_zero("after_reset_idle");
    endtask

    task automatic test_good();
        bq_t f;
        f = good_frame();
        expect_frame(f, 1'b1);
        send_frame(f, 0);
        wait_drain("good");
    endtask

    task automatic test_bad();
        bq_t f;
        f = good_frame();
        f[10] = 8'hE9;
        expect_frame(f, 1'b0);
        send_frame(f, 0);
        wait_drain("bad");
    endtask

    task automatic test_zero_payload();
        bq_t f;
        f = '{8'h00, 8'h00};
        expect_frame(f, 1'b1);
        send_frame(f, 0);
        wait_drain("zero_payload");
        f = '{8'h12, 8'h34};
        expect_frame(f, 1'b0);
        send_frame(f, 0);
        wait_drain("zero_payload_bad");
    endtask

    task automatic test_short();
        bq_t f;
        f = '{8'h5A};
        expect_frame(f, 1'b0);
        send_frame(f, 0);
        wait_drain("short");
    endtask

    task automatic test_reset_mid_frame();
        pay_q.push_back('{d: 8'h31, l: 1'b0});
        send_byte(8'h31, 1'b0);
        send_byte(8'h32, 1'b0);
        send_byte(8'h33, 1'b0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_outputs_zero("reset_async_mid_frame");
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (pay_q.size() != 0 || verd_q.size() != 0) begin
            errors++;
            $display("FAIL reset_partial: got %0d payload / %0d verdicts outstanding, expected 0/0",
                     pay_q.size(), verd_q.size());
            pay_q.delete();
            verd_q.delete();
        end
        exp_len = '0;
        gap(3);
        check_outputs_zero("reset_no_verdict");
        test_good();
    endtask

    task automatic test_back_to_back();
        bq_t f1, f2;
        f1 = good_frame();
        f2 = good_frame();
        f2[10] = 8'hE9;
        expect_frame(f1, 1'b1);
        expect_frame(f2, 1'b0);
        send_frame(f1, 3);
        send_frame(f2, 0);
        wait_drain("back_to_back");
    endtask

    // Random frames with reference CRC appended, back-to-back; one long enough to saturate frame_len
    task automatic test_random_saturation();
        bq_t    f;
        logic [15:0] c;
        int     lens[4];
        lens = '{20, 1, 15, 7};
        for (int k = 0; k < 4; k++) begin
            f.delete();
            for (int i = 0; i < lens[k]; i++) f.push_back(8'($urandom));
            c = ref_crc(f);
            f.push_back(c[15:8]);
            f.push_back(c[7:0]);
            if (k == 3) f[0] = f[0] ^ 8'h01;
            expect_frame(f, k != 3);
            send_frame(f, (k == 2) ? 2 : 0);
        end
        wait_drain("random_saturation");
    endtask

    initial begin
        test_reset();
        test_good();
        test_bad();
        test_zero_payload();
        test_short();
        test_reset_mid_frame();
        test_back_to_back();
        test_random_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
